// File: rtl/led_adder_axil_arbiter_if.sv
// AXI4-Lite register-bus bundle between the requester arbiter and the LED adder S00_AXI slave.
// Data is fixed at 32 bits; only the byte-address width is configurable.
interface led_adder_axil_arbiter_if #(
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/led_adder_axil_arbiter.sv
// Two-requester round-robin arbiter that serialises single-word register commands
// into AXI4-Lite transactions (one in flight) and pulses a response back to the requester.
module led_adder_axil_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [1:0]            rq_valid,
    output logic [1:0]            rq_ready,
    input  logic [1:0]            rq_write,
    input  logic [2*ADDR_W-1:0]   rq_addr,
    input  logic [2*DATA_W-1:0]   rq_wdata,
    output logic [1:0]            rs_valid,
    output logic [DATA_W-1:0]     rs_rdata,
    output logic [1:0]            rs_resp,
    led_adder_axil_arbiter_if.master m_axi
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR    = 3'd1,
        WR_B  = 3'd2,
        RD_AR = 3'd3,
        RD_R  = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t              state_reg, state_next;
    logic [1:0]          rq_ready_reg, rq_ready_next;
    logic                gnt_reg, gnt_next;
    logic                last_reg, last_next;
    logic                write_reg, write_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic                aw_done_reg, aw_done_next;
    logic                w_done_reg, w_done_next;
    logic                err_wait_reg, err_wait_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic [1:0]          resp_reg, resp_next;

    logic [ADDR_W-1:0]   req_addr  [2];
    logic [DATA_W-1:0]   req_wdata [2];
    logic                pick;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            assign req_addr[gi]  = rq_addr[gi*ADDR_W +: ADDR_W];
            assign req_wdata[gi] = rq_wdata[gi*DATA_W +: DATA_W];
            assign rs_valid[gi]  = (state_reg == RESP) && (gnt_reg == 1'(gi));
        end
    endgenerate

    // Under contention the requester that did not win last time goes next.
    assign pick = (&rq_valid) ? ~last_reg : rq_valid[1];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg    <= IDLE;
            rq_ready_reg <= '0;
            gnt_reg      <= 1'b0;
            last_reg     <= 1'b1;
            write_reg    <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            aw_done_reg  <= 1'b0;
            w_done_reg   <= 1'b0;
            err_wait_reg <= 1'b0;
            rdata_reg    <= '0;
            resp_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            rq_ready_reg <= rq_ready_next;
            gnt_reg      <= gnt_next;
            last_reg     <= last_next;
            write_reg    <= write_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            aw_done_reg  <= aw_done_next;
            w_done_reg   <= w_done_next;
            err_wait_reg <= err_wait_next;
            rdata_reg    <= rdata_next;
            resp_reg     <= resp_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rq_ready_next = '0;
        gnt_next      = gnt_reg;
        last_next     = last_reg;
        write_next    = write_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        aw_done_next  = aw_done_reg;
        w_done_next   = w_done_reg;
        err_wait_next = err_wait_reg;
        rdata_next    = rdata_reg;
        resp_next     = resp_reg;

        case (state_reg)
            IDLE: begin
                if (err_wait_reg) begin
                    err_wait_next = 1'b0;
                    state_next    = RESP;
                end else if (rq_ready_reg != 2'b00) begin
                    // Grant cycle: the command is latched, dispatch it now.
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                    if (addr_reg[1:0] != 2'b00) begin
                        // Misaligned: no bus access, answer SLVERR after a one-cycle turnaround.
                        resp_next     = 2'b10;
                        rdata_next    = '0;
                        err_wait_next = 1'b1;
                    end else if (write_reg) begin
                        state_next = WR;
                    end else begin
                        state_next = RD_AR;
                    end
                end else if (|rq_valid) begin
                    rq_ready_next = pick ? 2'b10 : 2'b01;
                    gnt_next      = pick;
                    last_next     = pick;
                    write_next    = rq_write[pick];
                    addr_next     = req_addr[pick];
                    wdata_next    = req_wdata[pick];
                end
            end
            WR: begin
                if (!aw_done_reg && m_axi.awready) aw_done_next = 1'b1;
                if (!w_done_reg && m_axi.wready)   w_done_next  = 1'b1;
                if (aw_done_next && w_done_next)   state_next   = WR_B;
            end
            WR_B: begin
                if (m_axi.bvalid) begin
                    resp_next  = m_axi.bresp;
                    rdata_next = '0;
                    state_next = RESP;
                end
            end
            RD_AR: begin
                if (m_axi.arready) state_next = RD_R;
            end
            RD_R: begin
                if (m_axi.rvalid) begin
                    rdata_next = m_axi.rdata;
                    resp_next  = m_axi.rresp;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign rq_ready = rq_ready_reg;
    assign rs_rdata = (state_reg == RESP) ? rdata_reg : '0;
    assign rs_resp  = (state_reg == RESP) ? resp_reg  : '0;

    assign m_axi.awaddr  = addr_reg;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = (state_reg == WR) && !aw_done_reg;
    assign m_axi.wdata   = wdata_reg;
    assign m_axi.wstrb   = 4'hF;
    assign m_axi.wvalid  = (state_reg == WR) && !w_done_reg;
    assign m_axi.bready  = (state_reg == WR_B);
    assign m_axi.araddr  = addr_reg;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = (state_reg == RD_AR);
    assign m_axi.rready  = (state_reg == RD_R);

endmodule
